// File: rtl/test_seq_pkg.sv
// Shared types for the test sequencer: FSM state encoding and the channel-index width helper.
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/test_seq_watchdog.sv
// Per-channel cycle watchdog: counts while enabled, clears on demand, flags the last allowed cycle.
module test_seq_watchdog #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] count_r;

    // Cycle counter; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + TO_W'(1);
        end
    end

    assign expire = en & (count_r == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/test_sequencer.sv
// Sequences N_TESTS sub-test channels over level start/finish handshakes with a per-channel watchdog.
// Optional TEST_SEQ_STOP_ON_FAIL_EN: first fail or timeout ends the sequence early.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_TESTS = 8,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             go,
    output logic [N_TESTS-1:0]               start,
    input  logic [N_TESTS-1:0]               finish,
    input  logic [N_TESTS-1:0]               fail,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [idx_width(N_TESTS)-1:0]    cur_idx,
    output logic [N_TESTS-1:0]               fail_mask,
    output logic [N_TESTS-1:0]               timeout_mask
);

    localparam int IDX_W = idx_width(N_TESTS);

    seq_state_e         state_r;
    logic [N_TESTS-1:0] start_r;
    logic [N_TESTS-1:0] fail_mask_r;
    logic [N_TESTS-1:0] timeout_mask_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [IDX_W-1:0]   cur_idx_r;

    logic               run_s;
    logic               fin_s;
    logic               ch_fail_s;
    logic               ch_to_s;
    logic               advance_s;
    logic               last_s;
    logic               stop_s;
    logic [N_TESTS-1:0] idx_onehot_s;
    logic [N_TESTS-1:0] fail_mask_nxt_s;
    logic [N_TESTS-1:0] timeout_mask_nxt_s;
    logic               wd_clr_s;
    logic               wd_expire_s;

    test_seq_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr_s),
        .en     (run_s),
        .expire (wd_expire_s)
    );

    // Verdict decode for the active channel; finish beats a coincident timeout.
    always_comb begin
        run_s        = (state_r == ST_RUN);
        idx_onehot_s = N_TESTS'(1) << cur_idx_r;
        if (run_s) begin
            fin_s = finish[cur_idx_r];
        end else begin
            fin_s = 1'b0;
        end
        ch_fail_s          = fin_s & fail[cur_idx_r];
        ch_to_s            = run_s & ~fin_s & wd_expire_s;
        advance_s          = fin_s | ch_to_s;
        wd_clr_s           = ~run_s | advance_s;
        last_s             = (cur_idx_r == IDX_W'(N_TESTS - 1));
        fail_mask_nxt_s    = fail_mask_r    | (ch_fail_s ? idx_onehot_s : {N_TESTS{1'b0}});
        timeout_mask_nxt_s = timeout_mask_r | (ch_to_s   ? idx_onehot_s : {N_TESTS{1'b0}});
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        stop_s = ch_fail_s | ch_to_s;
`else
        stop_s = 1'b0;
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            start_r        <= '0;
            fail_mask_r    <= '0;
            timeout_mask_r <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            cur_idx_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        fail_mask_r    <= '0;
                        timeout_mask_r <= '0;
                        done_r         <= 1'b0;
                        pass_r         <= 1'b0;
                        cur_idx_r      <= '0;
                        start_r        <= N_TESTS'(1);
                        busy_r         <= 1'b1;
                        state_r        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (advance_s) begin
                        fail_mask_r    <= fail_mask_nxt_s;
                        timeout_mask_r <= timeout_mask_nxt_s;
                        start_r        <= '0;
                        if (last_s || stop_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= ~|fail_mask_nxt_s & ~|timeout_mask_nxt_s;
                            state_r <= ST_DONE;
                        end else begin
                            cur_idx_r <= cur_idx_r + IDX_W'(1);
                            state_r   <= ST_GAP;
                        end
                    end
                end
                // One idle cycle so the next channel sees a clean rising start.
                ST_GAP: begin
                    start_r <= idx_onehot_s;
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_IDLE;
                    start_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign start        = start_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign cur_idx      = cur_idx_r;
    assign fail_mask    = fail_mask_r;
    assign timeout_mask = timeout_mask_r;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: channel responders, start-order/length scoreboard, verdict checks.
module tb_test_sequencer;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         go;
    logic [N-1:0] start;
    logic [N-1:0] finish;
    logic [N-1:0] fail;
    logic         busy;
    logic         done;
    logic         pass;
    logic [1:0]   cur_idx;
    logic [N-1:0] fail_mask;
    logic [N-1:0] timeout_mask;

    int           checks = 0;
    int           errors = 0;

    int           delay    [N];
    logic [N-1:0] never_fin;
    logic [N-1:0] fail_cfg;
    int           resp_cnt [N];

    typedef struct {
        int idx;
        int len;
    } exp_t;
    exp_t         exp_q[$];
    logic [N-1:0] prev_start;
    int           run_len;

    test_sequencer #(
        .N_TESTS (N),
        .TO_W    (16),
        .TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .start        (start),
        .finish       (finish),
        .fail         (fail),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .cur_idx      (cur_idx),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fail = fail_cfg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input int len);
        exp_t e;
        e.idx = idx;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Channel responders: raise finish once start has been high for delay[i] cycles.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n || !start[i]) begin
                resp_cnt[i] = 0;
                finish[i]   = 1'b0;
            end else begin
                resp_cnt[i] = resp_cnt[i] + 1;
                finish[i]   = !never_fin[i] && (resp_cnt[i] >= delay[i]);
            end
        end
    end

    // Scoreboard monitor: start order, gap before every rise, high-time per channel, one-hot.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = '0;
            run_len    = 0;
        end else begin
            check("start_onehot", 32'($countones(start) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (start[i] && !prev_start[i]) begin
                    check("gap_before_start", 32'(prev_start), 32'd0);
                    check("start_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("start_order", i, exp_q[0].idx);
                    run_len = 1;
                end else if (start[i] && prev_start[i]) begin
                    run_len = run_len + 1;
                end else if (!start[i] && prev_start[i]) begin
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("start_len", run_len, e.len);
                    end
                end
            end
            prev_start = start;
        end
    end

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_start(input int ch, input int max);
        int n = 0;
        while (!start[ch] && n < max) begin
            @(negedge clk);
            n++;
        end
        check("start_reached", 32'(start[ch]), 32'd1);
    endtask

    task automatic check_launch();
        check("launch_start", 32'(start), 32'd1);
        check("launch_busy", 32'(busy), 32'd1);
        check("launch_done", 32'(done), 32'd0);
        check("launch_idx", 32'(cur_idx), 32'd0);
    endtask

    task automatic check_result(input string tag, input int exp_pass, input int exp_idx,
                                input int exp_fm, input int exp_tm);
        check({tag, "_pass"}, 32'(pass), exp_pass);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_idx"}, 32'(cur_idx), exp_idx);
        check({tag, "_fmask"}, 32'(fail_mask), exp_fm);
        check({tag, "_tmask"}, 32'(timeout_mask), exp_tm);
        repeat (3) @(negedge clk);
        check({tag, "_held"}, 32'(done), 32'd1);
        check({tag, "_queue"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        never_fin = '0;
        fail_cfg = '0;
        for (int i = 0; i < N; i++) delay[i] = 5;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_idx", 32'(cur_idx), 32'd0);
        check("rst_masks", 32'({fail_mask, timeout_mask}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all channels pass
        for (int i = 0; i < N; i++) push_exp(i, 5);
        pulse_go();
        check_launch();
        wait_done(200);
        check_result("t1", 1, 3, 0, 0);

        // 2: channel 2 fails
        fail_cfg = 4'b0100;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        for (int i = 0; i < 3; i++) push_exp(i, 5);
        pulse_go();
        check_launch();
        wait_done(200);
        check_result("t2", 0, 2, 4'b0100, 0);
`else
        for (int i = 0; i < N; i++) push_exp(i, 5);
        pulse_go();
        check_launch();
        wait_done(200);
        check_result("t2", 0, 3, 4'b0100, 0);
`endif
        fail_cfg = '0;

        // 3: channel 1 never finishes, watchdog aborts after 20 cycles
        never_fin = 4'b0010;
        push_exp(0, 5);
        push_exp(1, 20);
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        pulse_go();
        wait_done(200);
        check_result("t3", 0, 1, 0, 4'b0010);
`else
        push_exp(2, 5);
        push_exp(3, 5);
        pulse_go();
        wait_done(200);
        check_result("t3", 0, 3, 0, 4'b0010);
`endif
        never_fin = '0;

        // 5: asynchronous reset mid-run on channel 1
`ifndef TEST_SEQ_STOP_ON_FAIL_EN
        fail_cfg = 4'b0001;
`endif
        for (int i = 0; i < N; i++) push_exp(i, 5);
        pulse_go();
        wait_start(1, 50);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_start", 32'(start), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_masks", 32'({fail_mask, timeout_mask}), 32'd0);
        check("t5_rst_idx", 32'(cur_idx), 32'd0);
        @(negedge clk);
        exp_q.delete();
        fail_cfg = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) push_exp(i, 5);
        pulse_go();
        check_launch();
        wait_done(200);
        check_result("t5", 1, 3, 0, 0);

        // 6: finish on the timeout cycle, go ignored in RUN, go in DONE restarts
        delay[1] = 20;
        fail_cfg = 4'b1000;
        push_exp(0, 5);
        push_exp(1, 20);
        push_exp(2, 5);
        push_exp(3, 5);
        pulse_go();
        wait_start(1, 50);
        pulse_go();
        check("t6_ignore_start", 32'(start), 32'd2);
        check("t6_ignore_idx", 32'(cur_idx), 32'd1);
        check("t6_ignore_busy", 32'(busy), 32'd1);
        wait_done(200);
        check_result("t6a", 0, 3, 4'b1000, 0);
        fail_cfg = '0;
        delay[1] = 5;
        for (int i = 0; i < N; i++) push_exp(i, 5);
        pulse_go();
        check("t6_clr_masks", 32'({fail_mask, timeout_mask}), 32'd0);
        check("t6_clr_pass", 32'(pass), 32'd0);
        check_launch();
        wait_done(200);
        check_result("t6b", 1, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
